alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Command-driven controller that sits on the driving side of the 4-bit ALU: it owns a 4-entry x 4-bit operand register file and accepts operation commands over a valid/ready handshake. For each command it drives the ALU operand/mode inputs from registers, captures the combinational result and overflow, writes the result back, and returns it over a valid/ready response port. The ALU itself stays external and is connected port-to-port.

Parameters:
NREGS, 4, register-file depth; fixed at 4 because addresses are 2 bits.
DW, 4, data width; fixed to match the ALU.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_mode  in  3  0 add, 1 sub, 2 compare, 3 and, 4 or, 5 not, 6 inc, 7 dec
cmd_ra  in  2  operand A register index
cmd_rb  in  2  operand B register index
cmd_rd  in  2  destination register index
cmd_cin  in  1  carry-in; used by add only
wr_en  in  1  host direct register write
wr_addr  in  2  host write index
wr_data  in  4  host write data
alu_a  out  4  to ALU A
alu_b  out  4  to ALU B
alu_cin  out  1  to ALU Cin
alu_mode  out  3  to ALU Mode
alu_r  in  4  from ALU R
alu_ovf  in  1  from ALU overFlow; high-Z for modes 2-7
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  4  captured result
rsp_ovf  out  1  qualified overflow
rsp_zero  out  1  1 when rsp_data == 0

Behaviour:
- Reset, asynchronous, any state:
  - state -> IDLE.
  - All four registers -> 0.
  - alu_a, alu_b, alu_cin, alu_mode -> 0.
  - rsp_valid, rsp_data, rsp_ovf -> 0; rsp_zero -> 1.
  - cmd_ready -> 1.
  - A pending operation is discarded, with no writeback.
- IDLE:
  - cmd_ready = 1 in IDLE only; combinational decode of state.
  - On cmd_valid && cmd_ready at edge T, register alu_a = reg[cmd_ra], alu_b = reg[cmd_rb], alu_mode = cmd_mode, and the latched rd.
  - alu_cin = cmd_cin when cmd_mode == 0, else 0.
  - Next state: DRIVE.
- DRIVE (one cycle; the ALU output settles):
  - At edge T+1, capture rsp_data = alu_r and write reg[rd] = alu_r.
  - rsp_ovf = alu_ovf when alu_mode is 0 or 1, else 0. The ALU's Z value must never be sampled into a register.
  - rsp_zero = (alu_r == 0).
  - Set rsp_valid = 1. Next state: RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid = 0 and next state IDLE.
  - No new command is accepted in that same cycle.
- Latency and throughput:
  - Accept to rsp_valid is exactly 2 cycles.
  - Minimum command spacing is 3 cycles.
- alu_* outputs hold their last value after the operation ends; they are not cleared.
- Operand aliasing: ra == rb, or rd equal to ra/rb, is legal. Operands are read at acceptance, so writeback does not affect the current operation.
- Host writes:
  - A host write is accepted in any state and updates the register at the next edge.
  - If a host write and the DRIVE writeback target the same register on the same edge, the writeback wins and the host write is dropped.
  - A host write to an operand register after acceptance does not affect the in-flight operation.
- Arithmetic: all modulo 16; the sequencer performs no arithmetic itself.

Optional Feature:
Macro STICKY_OVF_EN.
- Defined:
  - Adds output ovf_sticky (1 bit), reset 0.
  - Set at the DRIVE edge when the qualified overflow = 1.
  - Cleared only by reset or by a command with cmd_mode == 2 (compare) being accepted.
  - Set takes priority over clear in the same cycle; this cannot occur, and is asserted in simulation.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package alu_seq_pkg:
  - Mode constants MODE_ADD..MODE_DEC (3-bit).
  - State encoding ST_IDLE = 2'd0, ST_DRIVE = 2'd1, ST_RESP = 2'd2.
  - Widths DW = 4 and AW = 2.
- One sub-module, alu_seq_regfile:
  - 4x4 storage, two combinational read ports, one write port with internal priority mux (writeback over host), async active-low clear.
- The FSM and response registers live in the top module.

Test Plan:
- Host-load r0 = 4, r1 = 2; cmd add ra = 0, rb = 1, rd = 2, cin = 1 -> 2 cycles later rsp_data = 7, rsp_ovf per ALU add, rsp_zero = 0, and r2 = 7.
- r0 = 4'hF; cmd inc ra = 0, rd = 3 with ALU overFlow driven Z -> rsp_data = 0, rsp_zero = 1, rsp_ovf = 0 (not X), and r3 = 0.
- Cmd and (r0 = 3, r1 = 5) with rsp_ready held low 5 cycles -> rsp_valid and rsp_data = 1 stable throughout; cmd_ready = 0; a second cmd_valid is not accepted until 1 cycle after the response handshake.
- Same-edge host write wr_addr = 2, wr_data = 9 during DRIVE of a cmd with rd = 2 and result 6 -> r2 = 6.
- Assert rst_n low during DRIVE -> rsp_valid = 0 immediately, all registers 0, cmd_ready = 1 after release, and no writeback.
- With STICKY_OVF_EN: sub producing ALU overflow = 1 -> ovf_sticky = 1 persists across an add with no overflow; an accepted compare cmd -> ovf_sticky = 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared widths, ALU mode codes and FSM encoding for the ALU
//             operation sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int DW    = 4;
    localparam int AW    = 2;
    localparam int NREGS = 4;

    localparam logic [2:0] MODE_ADD = 3'd0;
    localparam logic [2:0] MODE_SUB = 3'd1;
    localparam logic [2:0] MODE_CMP = 3'd2;
    localparam logic [2:0] MODE_AND = 3'd3;
    localparam logic [2:0] MODE_OR  = 3'd4;
    localparam logic [2:0] MODE_NOT = 3'd5;
    localparam logic [2:0] MODE_INC = 3'd6;
    localparam logic [2:0] MODE_DEC = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // The ALU floats its overflow pin outside add/sub, so the mode gates it
    // before anything is registered.
    function automatic logic ovf_qualified(input logic [2:0] mode, input logic ovf);
        return ((mode == MODE_ADD) || (mode == MODE_SUB)) ? ovf : 1'b0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_regfile.sv
// ============================================================================
//  Module   : alu_seq_regfile
//  Purpose  : 4x4 operand register file, two async read ports, one write
//             port where sequencer writeback beats the host write.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          host_en,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data
);

    logic [DW-1:0] r_mem [NREGS];

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_entry
            localparam logic [AW-1:0] c_idx = AW'(i);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[i] <= '0;
                end else if (wb_en && (wb_addr == c_idx)) begin
                    r_mem[i] <= wb_data;
                end else if (host_en && (host_addr == c_idx)) begin
                    r_mem[i] <= host_data;
                end
            end
        end
    endgenerate

    assign ra_data = r_mem[ra_addr];
    assign rb_data = r_mem[rb_addr];

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Command-driven controller for an external 4-bit ALU: reads
//             operands, drives the ALU, captures and writes back the result,
//             and returns it over a valid/ready response port.
//  Options  : STICKY_OVF_EN adds the ovf_sticky output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
`ifdef STICKY_OVF_EN
    output logic          ovf_sticky,
`endif
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_mode,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [AW-1:0] cmd_rd,
    input  logic          cmd_cin,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_cin,
    output logic [2:0]    alu_mode,
    input  logic [DW-1:0] alu_r,
    input  logic          alu_ovf,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_ovf,
    output logic          rsp_zero
);

    state_t        r_state;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] w_rdata_a;
    logic [DW-1:0] w_rdata_b;
    logic          w_accept;
    logic          w_wb_en;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_wb_en   = (r_state == ST_DRIVE);

    alu_seq_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_addr   (cmd_ra),
        .rb_addr   (cmd_rb),
        .ra_data   (w_rdata_a),
        .rb_data   (w_rdata_b),
        .wb_en     (w_wb_en),
        .wb_addr   (r_rd),
        .wb_data   (alu_r),
        .host_en   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rd      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_mode  <= MODE_ADD;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            rsp_zero  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        alu_a    <= w_rdata_a;
                        alu_b    <= w_rdata_b;
                        alu_mode <= cmd_mode;
                        alu_cin  <= (cmd_mode == MODE_ADD) ? cmd_cin : 1'b0;
                        r_rd     <= cmd_rd;
                        r_state  <= ST_DRIVE;
                    end
                end
                // ALU outputs have had a full cycle to settle from alu_* regs.
                ST_DRIVE: begin
                    rsp_data  <= alu_r;
                    rsp_ovf   <= ovf_qualified(alu_mode, alu_ovf);
                    rsp_zero  <= (alu_r == '0);
                    rsp_valid <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef STICKY_OVF_EN
    logic w_sticky_set;
    logic w_sticky_clr;

    assign w_sticky_set = (r_state == ST_DRIVE) && ovf_qualified(alu_mode, alu_ovf);
    assign w_sticky_clr = w_accept && (cmd_mode == MODE_CMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (w_sticky_set) begin
            ovf_sticky <= 1'b1;
        end else if (w_sticky_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    // Set only happens in DRIVE and clear only in IDLE, so they never collide.
    a_sticky_excl: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(w_sticky_set && w_sticky_clr));
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
`default_nettype none

module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_mode;
    logic [1:0] cmd_ra, cmd_rb, cmd_rd;
    logic       cmd_cin;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] alu_a, alu_b;
    logic       alu_cin;
    logic [2:0] alu_mode;
    logic [3:0] alu_r;
    wire        alu_ovf;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_ovf;
    logic       rsp_zero;
`ifdef STICKY_OVF_EN
    logic       ovf_sticky;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef STICKY_OVF_EN
        .ovf_sticky(ovf_sticky),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rd    (cmd_rd),
        .cmd_cin   (cmd_cin),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_mode  (alu_mode),
        .alu_r     (alu_r),
        .alu_ovf   (alu_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .rsp_zero  (rsp_zero)
    );

    // External ALU: add carry-out / sub borrow as overflow, Z for other modes.
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin, input logic [2:0] m);
        case (m)
            3'd0:    return {1'b0, a} + {1'b0, b} + {4'b0, cin};
            3'd1:    return {(a < b), a - b};
            3'd2:    return {4'b0, (a < b)};
            3'd3:    return {1'b0, a & b};
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {1'b0, a + 4'd1};
            default: return {1'b0, a - 4'd1};
        endcase
    endfunction

    logic [4:0] alu_res;
    assign alu_res = alu_fn(alu_a, alu_b, alu_cin, alu_mode);
    assign alu_r   = alu_res[3:0];
    assign alu_ovf = (alu_mode <= 3'd1) ? alu_res[4] : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Presents a command for one edge; returns in DRIVE.
    task automatic cmd_go(input logic [2:0] m, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic cin);
        cmd_valid = 1'b1; cmd_mode = m; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_cin = cin;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp(input string tag, input logic [3:0] d, input logic ovf);
        step();
        chk({tag, "_valid"}, {3'b0, rsp_valid}, 4'd1);
        chk({tag, "_data"},  rsp_data, d);
        chk({tag, "_ovf"},   {3'b0, rsp_ovf}, {3'b0, ovf});
        chk({tag, "_zero"},  {3'b0, rsp_zero}, {3'b0, (d == 4'd0)});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_rd = '0; cmd_cin = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_cmd_ready", {3'b0, cmd_ready}, 4'd1);
        chk("rst_rsp_valid", {3'b0, rsp_valid}, 4'd0);
        chk("rst_rsp_data",  rsp_data, 4'd0);
        chk("rst_rsp_zero",  {3'b0, rsp_zero}, 4'd1);
        chk("rst_alu_a",     alu_a, 4'd0);
        chk("rst_alu_mode",  {1'b0, alu_mode}, 4'd0);
`ifdef STICKY_OVF_EN
        chk("rst_sticky",    {3'b0, ovf_sticky}, 4'd0);
`endif
        rst_n = 1'b1;
        step();

        // add r0(4)+r1(2)+cin -> r2 = 7
        host_wr(2'd0, 4'd4);
        host_wr(2'd1, 4'd2);
        cmd_go(3'd0, 2'd0, 2'd1, 2'd2, 1'b1);
        chk("add_busy",  {3'b0, cmd_ready}, 4'd0);
        chk("add_alu_a", alu_a, 4'd4);
        chk("add_alu_b", alu_b, 4'd2);
        chk("add_cin",   {3'b0, alu_cin}, 4'd1);
        chk("add_nrsp",  {3'b0, rsp_valid}, 4'd0);
        finish_rsp("add", 4'd7, 1'b0);
        cmd_go(3'd4, 2'd2, 2'd2, 2'd2, 1'b1);
        chk("or_cin_masked", {3'b0, alu_cin}, 4'd0);
        finish_rsp("rd_r2", 4'd7, 1'b0);

        // inc of F wraps to 0, overflow pin floats
        host_wr(2'd0, 4'hF);
        host_wr(2'd3, 4'd5);
        cmd_go(3'd6, 2'd0, 2'd0, 2'd3, 1'b0);
        finish_rsp("inc", 4'd0, 1'b0);
        cmd_go(3'd4, 2'd3, 2'd3, 2'd3, 1'b0);
        finish_rsp("rd_r3", 4'd0, 1'b0);

        // F+2 carries out; rd aliases rb
        cmd_go(3'd0, 2'd0, 2'd1, 2'd1, 1'b0);
        finish_rsp("add_ovf", 4'd1, 1'b1);
        cmd_go(3'd4, 2'd1, 2'd1, 2'd1, 1'b0);
        finish_rsp("rd_r1", 4'd1, 1'b0);

        // backpressure: and 3&5 held 5 cycles, queued sub waits for handshake
        host_wr(2'd0, 4'd3);
        host_wr(2'd1, 4'd5);
        cmd_go(3'd3, 2'd0, 2'd1, 2'd0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_ra = 2'd1; cmd_rb = 2'd0;
                cmd_rd = 2'd3; cmd_cin = 1'b1;
            end
            chk("hold_valid", {3'b0, rsp_valid}, 4'd1);
            chk("hold_data",  rsp_data, 4'd1);
            chk("hold_ready", {3'b0, cmd_ready}, 4'd0);
            step();
        end
        chk("hold_mode", {1'b0, alu_mode}, 4'd3);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_valid", {3'b0, rsp_valid}, 4'd0);
        chk("hs_ready", {3'b0, cmd_ready}, 4'd1);
        chk("hs_noacc", {1'b0, alu_mode}, 4'd3);
        step();
        cmd_valid = 1'b0;
        chk("q_busy",  {3'b0, cmd_ready}, 4'd0);
        chk("q_mode",  {1'b0, alu_mode}, 4'd1);
        chk("q_alu_a", alu_a, 4'd5);
        chk("q_alu_b", alu_b, 4'd1);
        chk("q_cin",   {3'b0, alu_cin}, 4'd0);
        finish_rsp("sub", 4'd4, 1'b0);

        // writeback beats a same-edge host write to r2
        cmd_go(3'd0, 2'd1, 2'd0, 2'd2, 1'b0);
        host_wr(2'd2, 4'd9);
        chk("coll_data", rsp_data, 4'd6);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        cmd_go(3'd4, 2'd2, 2'd2, 2'd2, 1'b0);
        finish_rsp("rd_coll", 4'd6, 1'b0);

        // host write to an operand in flight does not change the result
        cmd_go(3'd0, 2'd1, 2'd1, 2'd3, 1'b0);
        host_wr(2'd1, 4'd0);
        chk("inflt_data", rsp_data, 4'hA);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        cmd_go(3'd4, 2'd1, 2'd1, 2'd1, 1'b0);
        finish_rsp("rd_r1b", 4'd0, 1'b0);

        // reset in DRIVE: A+A would write 4 into r0
        cmd_go(3'd0, 2'd3, 2'd3, 2'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {3'b0, rsp_valid}, 4'd0);
        chk("arst_ready", {3'b0, cmd_ready}, 4'd1);
        chk("arst_zero",  {3'b0, rsp_zero}, 4'd1);
        chk("arst_alu_a", alu_a, 4'd0);
        #1 rst_n = 1'b1;
        step();
        chk("post_valid", {3'b0, rsp_valid}, 4'd0);
        chk("post_ready", {3'b0, cmd_ready}, 4'd1);
        cmd_go(3'd4, 2'd0, 2'd2, 2'd0, 1'b0);
        finish_rsp("rst_r0r2", 4'd0, 1'b0);
        cmd_go(3'd4, 2'd1, 2'd3, 2'd1, 1'b0);
        finish_rsp("rst_r1r3", 4'd0, 1'b0);

`ifdef STICKY_OVF_EN
        host_wr(2'd0, 4'd1);
        host_wr(2'd1, 4'd2);
        cmd_go(3'd1, 2'd0, 2'd1, 2'd3, 1'b0);
        finish_rsp("stk_sub", 4'hF, 1'b1);
        chk("stk_set", {3'b0, ovf_sticky}, 4'd1);
        cmd_go(3'd0, 2'd0, 2'd0, 2'd2, 1'b0);
        finish_rsp("stk_add", 4'd2, 1'b0);
        chk("stk_keep", {3'b0, ovf_sticky}, 4'd1);
        cmd_go(3'd2, 2'd0, 2'd1, 2'd2, 1'b0);
        chk("stk_clr", {3'b0, ovf_sticky}, 4'd0);
        finish_rsp("stk_cmp", 4'd1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
